// File: rtl/dmem_io_param.sv
// dmem_io_param: parametrised data RAM plus memory-mapped switch, timer and display IO page
module dmem_io_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 128,
  parameter int NUM_SW = 2,
  parameter int DISP_W = 7,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hfff0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_write,
  input  logic              dm_read,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_rvalid,
  output logic              dm_err,
  input  logic [NUM_SW-1:0] io_sw,
  output logic [DISP_W-1:0] io_display,
  output logic              io_irq
);
  localparam int RAM_AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_val, count, reload, disp;
  logic [NUM_SW-1:0] sync1, sync2, sync3, edge_q;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0] off;
  logic is_ram, is_io, sel_sw, sel_edge, sel_tmr, sel_tctrl, sel_disp, mapped;
  logic wr_edge, wr_tmr, wr_tctrl, wr_disp, t_en, t_irq_en, expired, expire;
  assign is_ram = dm_addr < ADDR_W'(DEPTH);
  assign ram_idx = dm_addr[RAM_AW-1:0];
  assign is_io = dm_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4];
  assign off = dm_addr[3:0];
  assign sel_sw = is_io && off == 4'd0;
  assign sel_edge = is_io && off == 4'd2;
  assign sel_tmr = is_io && off == 4'd4;
  assign sel_tctrl = is_io && off == 4'd6;
  assign sel_disp = is_io && off == 4'd10;
  assign mapped = is_ram | sel_sw | sel_edge | sel_tmr | sel_tctrl | sel_disp;
  assign wr_edge = dm_write & sel_edge;
  assign wr_tmr = dm_write & sel_tmr;
  assign wr_tctrl = dm_write & sel_tctrl;
  assign wr_disp = dm_write & sel_disp;
  // a TIMER load in the same cycle pre-empts the reload and its expiry
  assign expire = t_en & (count == '0) & ~wr_tmr;
  assign io_display = disp[DISP_W-1:0];
  assign io_irq = expired & t_irq_en;
  always_comb begin
    rd_val = is_ram ? mem[ram_idx] :
             sel_sw ? DATA_W'(sync2) :
             sel_edge ? DATA_W'(edge_q) :
             sel_tmr ? count :
             sel_tctrl ? DATA_W'({expired, t_irq_en, t_en}) :
             sel_disp ? disp : '0;
  end
  always_ff @(posedge clock) begin
    if (reset_n && dm_write && is_ram) mem[ram_idx] <= dm_wdata;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dm_rdata <= '0;
      dm_rvalid <= 1'b0;
      dm_err <= 1'b0;
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      edge_q <= '0;
      count <= '0;
      reload <= '0;
      t_en <= 1'b0;
      t_irq_en <= 1'b0;
      expired <= 1'b0;
      disp <= '0;
    end else begin
      dm_rvalid <= dm_read;
      dm_rdata <= dm_read ? rd_val : dm_rdata;
      dm_err <= (dm_read | dm_write) & ~mapped;
      sync1 <= io_sw;
      sync2 <= sync1;
      sync3 <= sync2;
      edge_q <= (edge_q & ~({NUM_SW{wr_edge}} & dm_wdata[NUM_SW-1:0])) | (sync2 & ~sync3);
      count <= wr_tmr ? dm_wdata : !t_en ? count : count == '0 ? reload : count - DATA_W'(1);
      reload <= wr_tmr ? dm_wdata : reload;
      t_en <= wr_tctrl ? dm_wdata[0] : t_en;
      t_irq_en <= wr_tctrl ? dm_wdata[1] : t_irq_en;
      expired <= expire | (expired & ~(wr_tctrl & dm_wdata[2]));
      disp <= wr_disp ? dm_wdata : disp;
    end
  end
endmodule
